// File: rtl/alu_sequencer_if.sv
// Command/response handshake bundle for alu_sequencer.
// master = command source / response sink, slave = sequencer.
interface alu_sequencer_if #(
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_op;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic              cmd_cin;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [DATA_W-1:0] rsp_hi;
    logic              rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_hi, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_hi, rsp_err
    );
endinterface

// File: rtl/alu_sequencer.sv
// Command-driven controller for an external 8-op combinational ALU.
// Define MUL_SEQ_EN to enable op 8: shift-add multiply over DATA_W ADD cycles.
module alu_sequencer #(
    parameter int         DATA_W   = 8,
    parameter logic [3:0] FLAG_RST = 4'b0000
) (
    input  logic              clk,
    input  logic              rst,
    alu_sequencer_if.slave    bus,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_cin,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_A,
    input  logic              alu_E,
    input  logic              alu_C,
    output logic              flag_a,
    output logic              flag_e,
    output logic              flag_z,
    output logic              flag_c
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SHR = 3'd1;
    localparam logic [2:0] OP_SHL = 3'd2;
    localparam logic [2:0] OP_CMP = 3'd7;

`ifdef MUL_SEQ_EN
    typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;
    localparam int CW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
    logic [DATA_W-1:0] acc_hi;
    logic [DATA_W-1:0] acc_lo;
    logic [DATA_W-1:0] mcand;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] hi_next;
    logic [DATA_W-1:0] lo_next;
`else
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
`endif

    state_t            state;
    state_t            state_next;
    logic [3:0]        op_reg;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic              cin_reg;
    logic [DATA_W-1:0] rsp_data;
    logic [DATA_W-1:0] rsp_hi;
    logic              rsp_err;

    assign bus.cmd_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_data  = rsp_data;
    assign bus.rsp_hi    = rsp_hi;
    assign bus.rsp_err   = rsp_err;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic and ALU operand steering.
    always_comb begin
        state_next = state;
        alu_a      = a_reg;
        alu_b      = b_reg;
        alu_cin    = cin_reg;
        alu_op     = op_reg[2:0];
`ifdef MUL_SEQ_EN
        hi_next = {alu_C, alu_out[DATA_W-1:1]};
        lo_next = {alu_out[0], acc_lo[DATA_W-1:1]};
`endif
        unique case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
`ifdef MUL_SEQ_EN
                    if (bus.cmd_op == 4'd8) state_next = MUL;
                    else                    state_next = EXEC;
`else
                    state_next = EXEC;
`endif
                end
            end
            EXEC: state_next = RESP;
`ifdef MUL_SEQ_EN
            MUL: begin
                alu_op  = OP_ADD;
                alu_a   = acc_hi;
                alu_b   = acc_lo[0] ? mcand : '0;
                alu_cin = 1'b0;
                if (cnt == LAST) state_next = RESP;
            end
`endif
            RESP: if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, result/flag update and multiply accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg   <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            cin_reg  <= 1'b0;
            rsp_data <= '0;
            rsp_hi   <= '0;
            rsp_err  <= 1'b0;
            {flag_a, flag_e, flag_z, flag_c} <= FLAG_RST;
`ifdef MUL_SEQ_EN
            acc_hi <= '0;
            acc_lo <= '0;
            mcand  <= '0;
            cnt    <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        op_reg  <= bus.cmd_op;
                        a_reg   <= bus.cmd_a;
                        b_reg   <= bus.cmd_b;
                        cin_reg <= bus.cmd_cin & flag_c;
`ifdef MUL_SEQ_EN
                        acc_hi <= '0;
                        acc_lo <= bus.cmd_b;
                        mcand  <= bus.cmd_a;
                        cnt    <= '0;
`endif
                    end
                end
                EXEC: begin
                    rsp_hi <= '0;
                    // op 8 only lands here when it is unsupported
                    if (op_reg[3]) begin
                        rsp_err  <= 1'b1;
                        rsp_data <= '0;
                    end else begin
                        rsp_err <= 1'b0;
                        if (op_reg[2:0] == OP_CMP) begin
                            rsp_data <= '0;
                            flag_a   <= alu_A;
                            flag_e   <= alu_E;
                            flag_z   <= alu_E;
                        end else begin
                            rsp_data <= alu_out;
                            flag_z   <= (alu_out == '0);
                        end
                        if (op_reg[2:0] == OP_ADD) flag_c <= alu_C;
                        if (op_reg[2:0] == OP_SHR) flag_c <= b_reg[0];
                        if (op_reg[2:0] == OP_SHL) flag_c <= b_reg[DATA_W-1];
                    end
                end
`ifdef MUL_SEQ_EN
                MUL: begin
                    acc_hi <= hi_next;
                    acc_lo <= lo_next;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        rsp_data <= lo_next;
                        rsp_hi   <= hi_next;
                        rsp_err  <= 1'b0;
                        flag_z   <= (lo_next == '0);
                        flag_c   <= (hi_next != '0);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU, directed plus random ops.
// Expected results come from a plain-arithmetic reference model of each command.
module tb_alu_sequencer;

    localparam int W = 8;
`ifdef MUL_SEQ_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] alu_a, alu_b, alu_out;
    logic         alu_cin, alu_gt, alu_eq, alu_co;
    logic [2:0]   alu_op;
    logic         flag_a, flag_e, flag_z, flag_c;
    logic [W:0]   sum;

    int n_checks = 0;
    int n_fail   = 0;

    logic m_a, m_e, m_z, m_c;

    alu_sequencer_if #(.DATA_W(W)) bus ();

    alu_sequencer #(.DATA_W(W), .FLAG_RST(4'b0000)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
        .alu_out(alu_out), .alu_A(alu_gt), .alu_E(alu_eq), .alu_C(alu_co),
        .flag_a(flag_a), .flag_e(flag_e), .flag_z(flag_z), .flag_c(flag_c)
    );

    always #5 clk = ~clk;

    // Combinational ALU the sequencer drives.
    always_comb begin
        sum    = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_cin};
        alu_co = sum[W];
        alu_gt = (alu_a > alu_b);
        alu_eq = (alu_a == alu_b);
        case (alu_op)
            3'd0: alu_out = sum[W-1:0];
            3'd1: alu_out = {alu_cin, alu_b[W-1:1]};
            3'd2: alu_out = {alu_b[W-2:0], alu_cin};
            3'd3: alu_out = ~alu_a;
            3'd4: alu_out = alu_a & alu_b;
            3'd5: alu_out = alu_a | alu_b;
            3'd6: alu_out = alu_a ^ alu_b;
            default: alu_out = '0;
        endcase
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic ci, output logic [7:0] d, output logic [7:0] h,
                            output logic e, output int lat);
        int s;
        int p;
        d = 8'h00; h = 8'h00; e = 1'b0; lat = 2;
        if (op == 4'd8 && MUL_EN) begin
            p   = int'(a) * int'(b);
            d   = p[7:0];
            h   = p[15:8];
            m_z = (d == 8'h00);
            m_c = (h != 8'h00);
            lat = 1 + W;
        end else if (op > 4'd7) begin
            e = 1'b1;
        end else begin
            case (op)
                4'd0: begin
                    s = int'(a) + int'(b) + (ci ? 1 : 0);
                    d = s[7:0];
                    m_c = (s > 255);
                end
                4'd1: begin
                    d = 8'(b / 2) + (ci ? 8'h80 : 8'h00);
                    m_c = (b % 2 == 1);
                end
                4'd2: begin
                    d = 8'(int'(b) * 2) + (ci ? 8'h01 : 8'h00);
                    m_c = (b >= 8'd128);
                end
                4'd3: d = ~a;
                4'd4: d = a & b;
                4'd5: d = a | b;
                4'd6: d = a ^ b;
                default: begin
                    m_a = (a > b);
                    m_e = (a == b);
                end
            endcase
            if (op == 4'd7) m_z = m_e;
            else            m_z = (d == 8'h00);
        end
    endtask

    task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input int hold);
        logic [7:0] ed, eh;
        logic       ee, ci;
        int         el, lat, w;
        logic [16:0] snap;
        ci = cin & m_c;
        model_op(op, a, b, ci, ed, eh, ee, el);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_cin   = cin;
        w = 0;
        while (!bus.cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("cmd_ready_wait", 32'(w < 20), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("busy_not_ready", 32'(bus.cmd_ready), 32'd0);
        if (op < 4'd8) begin
            chk("alu_drive", {8'h00, alu_a, alu_b, 4'(alu_op), 4'(alu_cin)},
                {8'h00, a, b, 4'(op[2:0]), 4'(ci)});
        end else if (op == 4'd8 && MUL_EN) begin
            chk("mul_drive", {20'h0, alu_a, 1'b0, alu_op, alu_cin}, 32'd0);
        end
        lat = 1;
        while (!bus.rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(el));
        chk("rsp_data", 32'(bus.rsp_data), 32'(ed));
        chk("rsp_hi", 32'(bus.rsp_hi), 32'(eh));
        chk("rsp_err", 32'(bus.rsp_err), 32'(ee));
        chk("flags", 32'({flag_a, flag_e, flag_z, flag_c}), 32'({m_a, m_e, m_z, m_c}));
        snap = {bus.rsp_data, bus.rsp_hi, bus.rsp_err};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_stable", 32'({bus.rsp_data, bus.rsp_hi, bus.rsp_err, bus.rsp_valid, bus.cmd_ready}),
                32'({snap, 2'b10}));
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("after_hs", 32'({bus.rsp_valid, bus.cmd_ready}), 32'b01);
    endtask

    initial begin
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 4'd0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_cin   = 1'b0;
        bus.rsp_ready = 1'b0;
        {m_a, m_e, m_z, m_c} = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_hs", 32'({bus.cmd_ready, bus.rsp_valid}), 32'b10);
        chk("rst_rsp", 32'({bus.rsp_data, bus.rsp_hi, bus.rsp_err}), 32'd0);
        chk("rst_flags", 32'({flag_a, flag_e, flag_z, flag_c}), 32'd0);
        chk("rst_alu", {8'h00, alu_a, alu_b, 4'(alu_op), 4'(alu_cin)}, 32'd0);

        do_op(4'd0, 8'hFF, 8'h01, 1'b0, 0);
        do_op(4'd0, 8'h00, 8'h00, 1'b1, 1);
        do_op(4'd7, 8'h80, 8'h7F, 1'b0, 0);
        do_op(4'd0, 8'hFF, 8'h01, 1'b0, 0);
        do_op(4'd1, 8'h00, 8'h81, 1'b1, 5);
        do_op(4'd2, 8'h00, 8'h80, 1'b1, 0);
        do_op(4'd7, 8'h33, 8'h33, 1'b0, 0);
        do_op(4'd3, 8'h5A, 8'h00, 1'b0, 0);
        do_op(4'd4, 8'hF0, 8'h3C, 1'b0, 0);
        do_op(4'd5, 8'hF0, 8'h0C, 1'b0, 0);
        do_op(4'd6, 8'hAA, 8'hAA, 1'b0, 0);
        do_op(4'd9, 8'h12, 8'h34, 1'b0, 0);
        do_op(4'd8, 8'h0F, 8'h11, 1'b0, 0);
        do_op(4'd8, 8'hFF, 8'hFF, 1'b0, 2);
        do_op(4'd15, 8'h01, 8'h02, 1'b1, 0);

        for (int i = 0; i < 40; i++) begin
            do_op(4'($urandom_range(0, 10)), 8'($urandom), 8'($urandom),
                  1'($urandom), int'($urandom_range(0, 3)));
        end

        bus.cmd_valid = 1'b1;
        bus.cmd_op    = MUL_EN ? 4'd8 : 4'd0;
        bus.cmd_a     = 8'hC3;
        bus.cmd_b     = 8'h5D;
        bus.cmd_cin   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        if (MUL_EN) repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        {m_a, m_e, m_z, m_c} = 4'b0000;
        chk("midop_rst_hs", 32'({bus.cmd_ready, bus.rsp_valid}), 32'b10);
        chk("midop_rst_flags", 32'({flag_a, flag_e, flag_z, flag_c}), 32'd0);
        chk("midop_rst_alu", {8'h00, alu_a, alu_b, 4'(alu_op), 4'(alu_cin)}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("no_rsp_after_rst", 32'(bus.rsp_valid), 32'd0);
        end
        do_op(4'd9, 8'h00, 8'h00, 1'b0, 0);
        do_op(4'd0, 8'h7F, 8'h80, 1'b1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
